up_counter_with_load: RTL and testbench
=======================================

Name: up_counter_with_load

Overview:
8-bit synchronous up-counter with a parallel-load input and a count enable. It is a general-purpose counting primitive for timers, address generators and event counters. It runs in a single clock domain. The load path lets a controller preset the count to any value before counting resumes.

Parameters:
WIDTH, 8, bit width of the data input and of the counter output.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
out  output  WIDTH  current count value, driven directly from a register.
data  input  WIDTH  parallel-load value, captured when load=1.
load  input  1  synchronous parallel-load request, active-high.
enable  input  1  count enable, active-high.

Behaviour:
- One clock (clk); reset is synchronous and active-high. No asynchronous reset path.
- Priority on each rising edge of clk, highest first:
  1. reset=1: out <= 0.
  2. Else load=1: out <= data. This applies regardless of enable.
  3. Else enable=1: out <= out + 1, modulo 2^WIDTH (255 wraps to 0).
  4. Else: out holds its value.
- Latency: every update is visible on out one clock edge after the controlling inputs are sampled. There is no combinational path from any input to out.
- Reset value: out = 0. While reset is held, out stays 0 whatever load, enable and data are doing.
- Reset released: counting or loading takes effect from the first edge at which reset=0.
- Load held for N cycles: out equals data after every one of those edges. No increment happens while load=1.
- data changing while load=1: out follows the data value sampled at each edge.
- Wrap-around: with enable=1, 8'hFF becomes 8'h00 on the next edge. There is no carry or overflow flag.
- Reset asserted mid-count or mid-load: out goes to 0 on the next edge and the in-progress operation is discarded.
- load and enable must be driven to known levels whenever reset=0. Their values are don't-care while reset=1.
- The count arithmetic is unsigned, WIDTH bits wide, and the carry-out is discarded.

Decomposition:
- Shared package: a WIDTH default constant (8) and a count typedef (logic [WIDTH-1:0]) for reuse by instantiating blocks.
- No sub-module. The next-state selection (reset/load/increment/hold mux) plus one register fits in a single module.

Test Plan:
- Reset: hold reset=1 for 1 edge with enable=1 and data=5 -> out=0.
- Count: release reset with enable=1, load=0 and run 10 edges -> out steps 1,2,…,10.
- Mid-count reset: assert reset=1 for 1 edge -> out=0.
- Load: release reset with load=1, data=5 and enable=1 held for 2 edges -> out=5 on both edges, no increment.
- Load release: drop load to 0 with enable=1 for 2 edges -> out=6, then 7.
- Hold and wrap: load data=8'hFE, then enable=0 for 3 edges -> out stays 8'hFE. Then enable=1 for 3 edges -> out goes 8'hFF, 8'h00, 8'h01.

Source files
------------

// File: rtl/up_counter_with_load_pkg.sv
// up_counter_with_load_pkg: shared width default and count type for counter users
package up_counter_with_load_pkg;
    localparam int WIDTH = 8;
    typedef logic [WIDTH-1:0] count_t;
endpackage

// File: rtl/up_counter_with_load_if.sv
// up_counter_with_load_if: control/data bundle between a controller and the counter
interface up_counter_with_load_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] data;
    logic             load;
    logic             enable;
    logic [WIDTH-1:0] out;
    modport master (output data, load, enable, input out);
    modport slave (input data, load, enable, output out);
endinterface

// File: rtl/up_counter_with_load.sv
// up_counter_with_load: synchronous up-counter with parallel load and count enable
module up_counter_with_load
    import up_counter_with_load_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    up_counter_with_load_if.slave  bus
);
    count_t q;
    count_t q_next;
    // priority: reset, then load, then increment (carry discarded), else hold
    always_comb begin
        q_next = reset ? '0 : bus.load ? bus.data : bus.enable ? q + 1'b1 : q;
    end
    always_ff @(posedge clk) begin
        q <= q_next;
    end
    assign bus.out = q;
endmodule

// File: tb/tb_up_counter_with_load.sv
// tb_up_counter_with_load: directed scenarios with hand-computed expected counts
module tb_up_counter_with_load;
    logic clk = 1'b0;
    logic reset;
    int tests_run = 0;
    int failures = 0;

    up_counter_with_load_if #(.WIDTH(8)) bus ();

    up_counter_with_load dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.load = 1'b0; bus.enable = 1'b1; bus.data = 8'd5;
        step();
        tests_run++;
        if (bus.out !== 8'd0) begin
            failures++;
            $display("FAIL reset: out=%0h expected 0", bus.out);
        end
    endtask

    task automatic test_count();
        reset = 1'b0; bus.load = 1'b0; bus.enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            tests_run++;
            if (bus.out !== 8'(i)) begin
                failures++;
                $display("FAIL count[%0d]: out=%0h expected %0h", i, bus.out, 8'(i));
            end
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        step();
        tests_run++;
        if (bus.out !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset: out=%0h expected 0", bus.out);
        end
    endtask

    task automatic test_load();
        reset = 1'b0; bus.load = 1'b1; bus.data = 8'd5; bus.enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (bus.out !== 8'd5) begin
                failures++;
                $display("FAIL load[%0d]: out=%0h expected 5", i, bus.out);
            end
        end
    endtask

    task automatic test_load_release();
        logic [7:0] exp [2] = '{8'd6, 8'd7};
        bus.load = 1'b0; bus.enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (bus.out !== exp[i]) begin
                failures++;
                $display("FAIL load_release[%0d]: out=%0h expected %0h", i, bus.out, exp[i]);
            end
        end
    endtask

    task automatic test_load_tracking();
        logic [7:0] vals [3] = '{8'h10, 8'hA5, 8'h3C};
        bus.load = 1'b1; bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.data = vals[i];
            step();
            tests_run++;
            if (bus.out !== vals[i]) begin
                failures++;
                $display("FAIL load_track[%0d]: out=%0h expected %0h", i, bus.out, vals[i]);
            end
        end
    endtask

    task automatic test_reset_over_load();
        reset = 1'b1; bus.load = 1'b1; bus.data = 8'h33; bus.enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (bus.out !== 8'd0) begin
                failures++;
                $display("FAIL reset_over_load[%0d]: out=%0h expected 0", i, bus.out);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_hold_wrap();
        logic [7:0] exp [7] = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'h00, 8'h01};
        bus.load = 1'b1; bus.data = 8'hFE; bus.enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            bus.load = 1'b0;
            bus.enable = (i >= 3);
            tests_run++;
            if (bus.out !== exp[i]) begin
                failures++;
                $display("FAIL hold_wrap[%0d]: out=%0h expected %0h", i, bus.out, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_mid_reset();
        test_load();
        test_load_release();
        test_load_tracking();
        test_reset_over_load();
        test_hold_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
